// File: rtl/mux_n_way_stream_if.sv
// Handshake bundle for mux_n_way_stream. The producer/consumer side uses the
// master modport and the multiplexer uses the slave modport.
interface mux_n_way_stream_if #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = $clog2(WAYS)
);
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_chan;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_n_way_stream.sv
// Registered N-way stream multiplexer: explicit-select or round-robin grant
// into a one-entry output register with full 1 word/cycle throughput.
module mux_n_way_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = $clog2(WAYS)
) (
  input logic               clk,
  input logic               rst_n,
  mux_n_way_stream_if.slave bus
);

  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;
  logic [SEL_W-1:0] ptr_q;

  logic             load_ok;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             transfer;
  logic             pop;

  assign load_ok  = !valid_q || bus.out_ready;
  assign transfer = load_ok && grant_valid;
  assign pop      = valid_q && bus.out_ready;

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    int               j;
    logic [SEL_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    idx         = '0;
    if (!bus.mode) begin
      // An out-of-range select matches no channel and so grants nothing.
      for (int i = 0; i < WAYS; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        j = int'(ptr_q) + k;
        if (j >= WAYS) j = j - WAYS;
        idx = SEL_W'(j);
        if (!grant_valid && bus.in_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < WAYS; i++) begin
      bus.in_ready[i] = transfer && (grant_idx == SEL_W'(i));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (transfer) begin
      data_q  <= bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
      chan_q  <= grant_idx;
      valid_q <= 1'b1;
      ptr_q   <= (int'(grant_idx) == WAYS-1) ? '0 : grant_idx + 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

endmodule
